// File: rtl/fifo_arb_pkg.sv
// Shared definitions for the fifo write-port arbiter.
//   arb_state_t : arbiter FSM states (idle/arbitrating, granted)
//   STAT_W      : width of each per-requester transfer counter
package fifo_arb_pkg;

  typedef enum logic [0:0] {
    ARB_IDLE  = 1'b0,
    ARB_GRANT = 1'b1
  } arb_state_t;

  localparam int STAT_W = 16;

endpackage

// File: rtl/fifo_wr_arbiter_rr_picker.sv
// rr_picker: combinational rotating-priority selector.
// Scans req starting at rr_ptr, wrapping modulo NUM_REQ, and returns the
// first set bit.
//   req    : request vector, bit i = requester i wants the port
//   rr_ptr : highest-priority index this round
//   found  : at least one request is set
//   idx    : index of the selected requester (0 when none found)
module rr_picker
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   rr_ptr,
  output logic               found,
  output logic [IDX_W-1:0]   idx
);

  always_comb begin
    int j;
    logic [IDX_W-1:0] cand;
    found = 1'b0;
    idx   = '0;
    j     = 0;
    cand  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      // Explicit wrap keeps the index below NUM_REQ for non-power-of-2 counts.
      j = int'(rr_ptr) + k;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      cand = IDX_W'(j);
      if (!found && req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin arbiter sharing one fifo write port among
// NUM_REQ valid/ready producers. One producer is granted for a burst of up
// to MAX_BURST words; priority then rotates to the next index. Each grant
// costs one idle arbitration cycle.
// Ports:
//   clk, rst            : clock, asynchronous active-low reset
//   req_valid/req_data  : producer words, data i in [i*WIDTH +: WIDTH]
//   req_ready           : per-producer accept (owner only, when not full)
//   fifo_wr_en/fifo_din : fifo write side, fifo_full : fifo full flag
//   grant_valid/idx     : current owner of the port
// Optional (macro FIFO_ARB_STATS_EN):
//   stat_clr            : synchronous clear of all transfer counters
//   stat_count          : NUM_REQ saturating 16-bit transfer counters
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int WIDTH     = 8,
  parameter int MAX_BURST = 4,
  parameter int IDX_W     = $clog2(NUM_REQ),
  parameter int BURST_W   = $clog2(MAX_BURST + 1)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]       req_ready,
  output logic                     fifo_wr_en,
  output logic [WIDTH-1:0]         fifo_din,
  input  logic                     fifo_full,
  output logic                     grant_valid,
  output logic [IDX_W-1:0]         grant_idx
`ifdef FIFO_ARB_STATS_EN
  ,
  input  logic                     stat_clr,
  output logic [NUM_REQ*STAT_W-1:0] stat_count
`endif
);

  arb_state_t         state;
  logic [IDX_W-1:0]   rr_ptr;
  logic [IDX_W-1:0]   owner;
  logic [BURST_W-1:0] burst_cnt;
  logic               pick_found;
  logic [IDX_W-1:0]   pick_idx;
  logic               granted;
  logic               owner_valid;
  logic               xfer;
  logic               last_beat;
  logic [WIDTH-1:0]   data_arr [NUM_REQ];

  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] i);
    return (i == IDX_W'(NUM_REQ - 1)) ? '0 : i + 1'b1;
  endfunction

  rr_picker #(
    .NUM_REQ(NUM_REQ),
    .IDX_W  (IDX_W)
  ) u_picker (
    .req   (req_valid),
    .rr_ptr(rr_ptr),
    .found (pick_found),
    .idx   (pick_idx)
  );

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign data_arr[g] = req_data[g*WIDTH +: WIDTH];
  end

  // Write-side decode from registered state; fifo_full gates every handshake
  // so a write can never be issued into a full fifo.
  assign granted     = (state == ARB_GRANT);
  assign owner_valid = req_valid[owner];
  assign xfer        = granted && owner_valid && !fifo_full;
  assign last_beat   = (burst_cnt == BURST_W'(MAX_BURST - 1));

  assign fifo_wr_en  = xfer;
  assign fifo_din    = granted ? data_arr[owner] : '0;
  assign grant_valid = granted;
  assign grant_idx   = granted ? owner : '0;

  always_comb begin
    req_ready = '0;
    if (granted && !fifo_full) req_ready[owner] = 1'b1;
  end

  // Arbitration FSM: IDLE picks the next owner, GRANT streams the burst.
  // Full stalls hold the grant without spending burst budget; dropping
  // valid (stalled or not) releases it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ARB_IDLE;
      rr_ptr    <= '0;
      owner     <= '0;
      burst_cnt <= '0;
    end else begin
      case (state)
        ARB_IDLE: begin
          if (pick_found) begin
            owner     <= pick_idx;
            burst_cnt <= '0;
            state     <= ARB_GRANT;
          end
        end
        ARB_GRANT: begin
          if (!owner_valid || (xfer && last_beat)) begin
            state     <= ARB_IDLE;
            rr_ptr    <= next_idx(owner);
            burst_cnt <= '0;
          end else if (xfer) begin
            burst_cnt <= burst_cnt + 1'b1;
          end
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

`ifdef FIFO_ARB_STATS_EN
  logic [STAT_W-1:0] stat_cnt [NUM_REQ];

  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_stat
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        stat_cnt[g] <= '0;
      end else if (stat_clr) begin
        stat_cnt[g] <= '0;
      end else if (xfer && (owner == IDX_W'(g))) begin
        stat_cnt[g] <= sat_inc(stat_cnt[g]);
      end
    end
    assign stat_count[g*STAT_W +: STAT_W] = stat_cnt[g];
  end
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Testbench for fifo_wr_arbiter (NUM_REQ=4, WIDTH=8, MAX_BURST=4).
// Per-cycle vector table of inputs and expected outputs, followed by a
// hand-written fairness run and, with FIFO_ARB_STATS_EN, counter checks.
module tb_fifo_wr_arbiter;

  logic        clk;
  logic        rst;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_ready;
  logic        fifo_wr_en;
  logic [7:0]  fifo_din;
  logic        fifo_full;
  logic        grant_valid;
  logic [1:0]  grant_idx;
`ifdef FIFO_ARB_STATS_EN
  logic        stat_clr;
  logic [63:0] stat_count;
`endif

  int nvec = 0;
  int nerr = 0;

  fifo_wr_arbiter #(
    .NUM_REQ  (4),
    .WIDTH    (8),
    .MAX_BURST(4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .fifo_wr_en (fifo_wr_en),
    .fifo_din   (fifo_din),
    .fifo_full  (fifo_full),
    .grant_valid(grant_valid),
    .grant_idx  (grant_idx)
`ifdef FIFO_ARB_STATS_EN
    ,
    .stat_clr   (stat_clr),
    .stat_count (stat_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [3:0]  valid;
    logic [31:0] data;
    logic        full;
    logic [3:0]  ready;
    logic        wr;
    logic [7:0]  din;
    logic        gv;
    logic [1:0]  gidx;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic [3:0] v, input logic [31:0] d,
                     input logic f, input logic [3:0] rdy, input logic w,
                     input logic [7:0] di, input logic g, input logic [1:0] gi);
    vec_t e;
    e.rst = r; e.valid = v; e.data = d; e.full = f;
    e.ready = rdy; e.wr = w; e.din = di; e.gv = g; e.gidx = gi;
    vecs.push_back(e);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  logic [15:0] act_b, exp_b;
  int wcnt [4];

  initial begin
    rst = 1'b0; req_valid = '0; req_data = '0; fifo_full = 1'b0;
`ifdef FIFO_ARB_STATS_EN
    stat_clr = 1'b0;
`endif

    // Reset, then idle.
    add(0, 4'h0, 32'h0, 0, 4'h0, 0, 8'h00, 0, 2'd0);
    add(1, 4'h0, 32'h0, 0, 4'h0, 0, 8'h00, 0, 2'd0);
    // All four valid: bubble + 4 writes per owner, 0,1,2,3 then wrap to 0.
    for (int g = 0; g < 4; g++) begin
      add(1, 4'hF, 32'h44332211, 0, 4'h0, 0, 8'h00, 0, 2'd0);
      for (int b = 0; b < 4; b++)
        add(1, 4'hF, 32'h44332211, 0, 4'(1 << g), 1, 8'(8'h11 * (g + 1)), 1, 2'(g));
    end
    add(1, 4'hF, 32'h44332211, 0, 4'h0, 0, 8'h00, 0, 2'd0);
    add(1, 4'hF, 32'h44332211, 0, 4'h1, 1, 8'h11, 1, 2'd0);
    // Async reset mid-burst with all valid: outputs drop in the same cycle.
    add(0, 4'hF, 32'h44332211, 0, 4'h0, 0, 8'h00, 0, 2'd0);
    // Owner 2 after 2 words, then reset; first grant after release goes to 0.
    add(1, 4'h4, 32'h44332211, 0, 4'h0, 0, 8'h00, 0, 2'd0);
    add(1, 4'h4, 32'h44332211, 0, 4'h4, 1, 8'h33, 1, 2'd2);
    add(1, 4'h4, 32'h44332211, 0, 4'h4, 1, 8'h33, 1, 2'd2);
    add(0, 4'h4, 32'h44332211, 0, 4'h0, 0, 8'h00, 0, 2'd0);
    add(1, 4'hF, 32'h44332211, 0, 4'h0, 0, 8'h00, 0, 2'd0);
    add(1, 4'hF, 32'h44332211, 0, 4'h1, 1, 8'h11, 1, 2'd0);
    add(0, 4'h0, 32'h0, 0, 4'h0, 0, 8'h00, 0, 2'd0);
    // Single requester 1 with 6 words: 4 writes, bubble, 2 writes, release.
    add(1, 4'h2, 32'h0000A100, 0, 4'h0, 0, 8'h00, 0, 2'd0);
    add(1, 4'h2, 32'h0000A100, 0, 4'h2, 1, 8'hA1, 1, 2'd1);
    add(1, 4'h2, 32'h0000A200, 0, 4'h2, 1, 8'hA2, 1, 2'd1);
    add(1, 4'h2, 32'h0000A300, 0, 4'h2, 1, 8'hA3, 1, 2'd1);
    add(1, 4'h2, 32'h0000A400, 0, 4'h2, 1, 8'hA4, 1, 2'd1);
    add(1, 4'h2, 32'h0000A500, 0, 4'h0, 0, 8'h00, 0, 2'd0);
    add(1, 4'h2, 32'h0000A500, 0, 4'h2, 1, 8'hA5, 1, 2'd1);
    add(1, 4'h2, 32'h0000A600, 0, 4'h2, 1, 8'hA6, 1, 2'd1);
    add(1, 4'h0, 32'h0, 0, 4'h2, 0, 8'h00, 1, 2'd1);
    add(1, 4'h0, 32'h0, 0, 4'h0, 0, 8'h00, 0, 2'd0);
    // Full stall after owner 0's 2nd word: budget preserved, then rotate to 1.
    add(0, 4'h0, 32'h0, 0, 4'h0, 0, 8'h00, 0, 2'd0);
    add(1, 4'h3, 32'h00002211, 0, 4'h0, 0, 8'h00, 0, 2'd0);
    add(1, 4'h3, 32'h00002211, 0, 4'h1, 1, 8'h11, 1, 2'd0);
    add(1, 4'h3, 32'h00002211, 0, 4'h1, 1, 8'h11, 1, 2'd0);
    for (int s = 0; s < 3; s++)
      add(1, 4'h3, 32'h00002211, 1, 4'h0, 0, 8'h11, 1, 2'd0);
    add(1, 4'h3, 32'h00002211, 0, 4'h1, 1, 8'h11, 1, 2'd0);
    add(1, 4'h3, 32'h00002211, 0, 4'h1, 1, 8'h11, 1, 2'd0);
    add(1, 4'h3, 32'h00002211, 0, 4'h0, 0, 8'h00, 0, 2'd0);
    add(1, 4'h3, 32'h00002211, 0, 4'h2, 1, 8'h22, 1, 2'd1);
    // Owner 0 drops valid after 2 words with 1 and 3 valid -> next owner 1;
    // owner 1 drops valid while stalled on full -> next owner 3.
    add(0, 4'h0, 32'h0, 0, 4'h0, 0, 8'h00, 0, 2'd0);
    add(1, 4'hB, 32'h44002211, 0, 4'h0, 0, 8'h00, 0, 2'd0);
    add(1, 4'hB, 32'h44002211, 0, 4'h1, 1, 8'h11, 1, 2'd0);
    add(1, 4'hB, 32'h44002211, 0, 4'h1, 1, 8'h11, 1, 2'd0);
    add(1, 4'hA, 32'h44002211, 0, 4'h1, 0, 8'h11, 1, 2'd0);
    add(1, 4'hA, 32'h44002211, 0, 4'h0, 0, 8'h00, 0, 2'd0);
    add(1, 4'hA, 32'h44002211, 0, 4'h2, 1, 8'h22, 1, 2'd1);
    add(1, 4'h8, 32'h44002211, 1, 4'h0, 0, 8'h22, 1, 2'd1);
    add(1, 4'h8, 32'h44002211, 0, 4'h0, 0, 8'h00, 0, 2'd0);
    add(1, 4'h8, 32'h44002211, 0, 4'h8, 1, 8'h44, 1, 2'd3);
    add(0, 4'h0, 32'h0, 0, 4'h0, 0, 8'h00, 0, 2'd0);

    foreach (vecs[i]) begin
      @(negedge clk);
      rst = vecs[i].rst; req_valid = vecs[i].valid;
      req_data = vecs[i].data; fifo_full = vecs[i].full;
      #2;
      act_b = {req_ready, fifo_wr_en, fifo_din, grant_valid, grant_idx};
      exp_b = {vecs[i].ready, vecs[i].wr, vecs[i].din, vecs[i].gv, vecs[i].gidx};
      check($sformatf("vec%0d {ready,wr,din,gv,gidx}", i), 32'(act_b), 32'(exp_b));
    end

    // Fairness: 20 cycles from reset with all valid -> 16 writes, 4 each.
    for (int r = 0; r < 4; r++) wcnt[r] = 0;
    @(negedge clk);
    rst = 1'b1; req_valid = 4'hF; req_data = 32'h44332211; fifo_full = 1'b0;
    for (int c = 0; c < 20; c++) begin
      #2;
      if (c % 5 == 0) begin
        check($sformatf("fair c%0d wr,gv", c), {30'd0, fifo_wr_en, grant_valid}, 32'd0);
      end else begin
        check($sformatf("fair c%0d wr,gv,gidx", c),
              {28'd0, fifo_wr_en, grant_valid, grant_idx}, {28'd0, 1'b1, 1'b1, 2'(c / 5)});
      end
      if (fifo_wr_en) wcnt[grant_idx]++;
      @(negedge clk);
    end
    for (int r = 0; r < 4; r++)
      check($sformatf("fair writes req%0d", r), 32'(wcnt[r]), 32'd4);

`ifdef FIFO_ARB_STATS_EN
    #2;
    for (int r = 0; r < 4; r++)
      check($sformatf("stat_count[%0d] after rotation", r), 32'(stat_count[r*16 +: 16]), 32'd4);
    @(negedge clk);
    stat_clr = 1'b1;
    #2;
    check("clr cycle wr,gidx", {29'd0, fifo_wr_en, grant_idx}, {29'd0, 1'b1, 2'd0});
    @(negedge clk);
    stat_clr = 1'b0;
    #2;
    check("stat_count[0] after clr+xfer", 32'(stat_count[15:0]), 32'd0);
    check("stat_count[1] after clr", 32'(stat_count[31:16]), 32'd0);
    @(negedge clk);
    #2;
    check("stat_count[0] next xfer", 32'(stat_count[15:0]), 32'd1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
